row_sep_stream: RTL and testbench

//  Parametrised, streaming successor to the ME row separator. Accepts a packed ROWS x COLS

---
 rtl/row_sep_stream_pkg.sv | 15 +
 rtl/row_sep_stream_if.sv | 38 +++
 rtl/row_sep_stream_row_sep_mux.sv | 24 ++
 rtl/row_sep_stream.sv | 95 +++++++++
 tb/tb_row_sep_stream.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/row_sep_stream_pkg.sv
// Shared motion-estimation definitions: default pixel geometry and the
// column-major pixel indexing used by every block that touches a packed
// reference-pixel block.
package row_sep_stream_pkg;

    localparam int PIXEL_W  = 8;
    localparam int ROWS_DEF = 8;
    localparam int COLS_DEF = 32;

    // Bit offset of pixel (c,r) inside a column-major packed block.
    function automatic int pix_at(input int c, input int r, input int rows, input int pixel);
        return (c * rows + r) * pixel;
    endfunction

endpackage

// File: rtl/row_sep_stream_if.sv
// Block-in / row-out stream bundle for the row separator.
//
// Handshake (both channels): a transfer happens on a rising clock edge where
// valid and ready are both 1. ready is driven from the consumer's state only
// and never looks at valid. While valid is 1 and ready is 0 the producer's
// payload (and its valid) stays put.
interface row_sep_stream_if
    import row_sep_stream_pkg::*;
#(
    parameter int PIXEL = PIXEL_W,
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF
);
    localparam int RW = $clog2(ROWS);

    logic                        in_valid;
    logic                        in_ready;
    logic [ROWS*COLS*PIXEL-1:0]  in_blk;
    logic                        in_rev;
    logic                        out_valid;
    logic                        out_ready;
    logic [COLS*PIXEL-1:0]       out_row;
    logic [RW-1:0]               out_idx;
    logic                        out_last;

    // Block source and row sink side.
    modport master (
        output in_valid, in_blk, in_rev, out_ready,
        input  in_ready, out_valid, out_row, out_idx, out_last
    );

    // Row separator side.
    modport slave (
        input  in_valid, in_blk, in_rev, out_ready,
        output in_ready, out_valid, out_row, out_idx, out_last
    );

endinterface

// File: rtl/row_sep_stream_row_sep_mux.sv
// Generalised row separator: picks row idx out of a column-major block and
// packs it with column 0 in the most significant pixel position.
module row_sep_mux
    import row_sep_stream_pkg::*;
#(
    parameter int PIXEL = PIXEL_W,
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    localparam int RW   = $clog2(ROWS)
) (
    input  logic [ROWS*COLS*PIXEL-1:0] blk,
    input  logic [RW-1:0]              idx,
    output logic [COLS*PIXEL-1:0]      row
);

    // Gather pixel (c,idx) for every column into its output lane.
    always_comb begin
        row = '0;
        for (int c = 0; c < COLS; c++) begin
            row[(COLS-1-c)*PIXEL +: PIXEL] = blk[pix_at(c, int'(idx), ROWS, PIXEL) +: PIXEL];
        end
    end

endmodule

// File: rtl/row_sep_stream.sv
// Streaming row separator: buffers up to two reference blocks in a ping-pong
// store and emits one row per accepted output beat, top-down or bottom-up as
// chosen per block.
module row_sep_stream
    import row_sep_stream_pkg::*;
#(
    parameter int PIXEL = PIXEL_W,
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    row_sep_stream_if.slave  bus
);

    localparam int            RW       = $clog2(ROWS);
    localparam int            BW       = ROWS * COLS * PIXEL;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic [BW-1:0]         slot [2];
    logic [1:0]            rev;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [RW-1:0]         row_cnt;

    logic                  in_ready;
    logic                  out_valid;
    logic                  accept;
    logic                  pop;
    logic                  retire;
    logic [RW-1:0]         idx;
    logic [COLS*PIXEL-1:0] row_data;

    // Handshake and row-select decode, all from registered state.
    always_comb begin
        in_ready  = (count != 2'd2);
        out_valid = (count != 2'd0);
        accept    = bus.in_valid & in_ready;
        pop       = out_valid & bus.out_ready;
        retire    = pop & (row_cnt == LAST_ROW);
        idx       = rev[rd_ptr] ? (LAST_ROW - row_cnt) : row_cnt;
    end

    row_sep_mux #(
        .PIXEL (PIXEL),
        .ROWS  (ROWS),
        .COLS  (COLS)
    ) u_mux (
        .blk (slot[rd_ptr]),
        .idx (idx),
        .row (row_data)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_row   = row_data;
    assign bus.out_idx   = idx;
    assign bus.out_last  = out_valid & (row_cnt == LAST_ROW);

    // Buffer, pointers and occupancy; flush wipes everything like reset and
    // discards any transfer on the same edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            slot[0] <= '0;
            slot[1] <= '0;
            rev     <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            row_cnt <= '0;
        end else begin
            if (accept) begin
                slot[wr_ptr] <= bus.in_blk;
                rev[wr_ptr]  <= bus.in_rev;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                if (retire) begin
                    row_cnt <= '0;
                    rd_ptr  <= ~rd_ptr;
                end else begin
                    row_cnt <= row_cnt + RW'(1);
                end
            end
            case ({accept, retire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_row_sep_stream.sv
// Bench for row_sep_stream: one 8x32x8 instance (A) for the main scenarios and
// one 4x16x10 instance (B) for the alternate geometry.
module tb_row_sep_stream;

    localparam int AP = 8,  AR = 8, AC = 32, ARW = 3;
    localparam int ABW = AP * AR * AC, AOW = AP * AC, AEW = AOW + ARW + 1;
    localparam int BP = 10, BR = 4, BC = 16, BRW = 2;
    localparam int BBW = BP * BR * BC, BOW = BP * BC, BEW = BOW + BRW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Expected rows in emission order: {last, idx, row}.
    logic [AEW-1:0] exp_a[$];
    logic [BEW-1:0] exp_b[$];

    row_sep_stream_if #(.PIXEL(AP), .ROWS(AR), .COLS(AC)) bus_a ();
    row_sep_stream_if #(.PIXEL(BP), .ROWS(BR), .COLS(BC)) bus_b ();

    row_sep_stream #(.PIXEL(AP), .ROWS(AR), .COLS(AC)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .bus(bus_a));
    row_sep_stream #(.PIXEL(BP), .ROWS(BR), .COLS(BC)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .bus(bus_b));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [ABW-1:0] rand_blk_a();
        logic [ABW-1:0] v;
        for (int i = 0; i < ABW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [BBW-1:0] rand_blk_b();
        logic [BBW-1:0] v;
        for (int i = 0; i < BBW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Row r of the directed pattern pixel(c,r) = c*8 + r, column 0 first.
    function automatic logic [AOW-1:0] dir_row(input int r);
        logic [AOW-1:0] v;
        v = '0;
        for (int c = 0; c < AC; c++) v = {v[AOW-AP-1:0], 8'(c * 8 + r)};
        return v;
    endfunction

    task automatic push_a(input logic [ABW-1:0] blk, input logic rv);
        for (int k = 0; k < AR; k++) begin
            int r;
            logic [AOW-1:0] row;
            r = rv ? AR - 1 - k : k;
            row = '0;
            for (int c = 0; c < AC; c++) row = {row[AOW-AP-1:0], blk[(c*AR+r)*AP +: AP]};
            exp_a.push_back({k == AR - 1, ARW'(r), row});
        end
    endtask

    task automatic push_b(input logic [BBW-1:0] blk, input logic rv);
        for (int k = 0; k < BR; k++) begin
            int r;
            logic [BOW-1:0] row;
            r = rv ? BR - 1 - k : k;
            row = '0;
            for (int c = 0; c < BC; c++) row = {row[BOW-BP-1:0], blk[(c*BR+r)*BP +: BP]};
            exp_b.push_back({k == BR - 1, BRW'(r), row});
        end
    endtask

    // A slot is free when fewer than two blocks still have rows outstanding.
    function automatic bit ready_a();
        return ((exp_a.size() + AR - 1) / AR) < 2;
    endfunction

    function automatic bit ready_b();
        return ((exp_b.size() + BR - 1) / BR) < 2;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_blk = '0; bus_a.in_rev = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_blk = '0; bus_b.in_rev = 1'b0; bus_b.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus_a.in_ready); end
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus_a.out_valid); end
        checks++; if (bus_a.out_row !== '0) begin errors++; $display("FAIL reset_out_row got %h want 0", bus_a.out_row); end
        checks++; if (bus_a.out_idx !== '0) begin errors++; $display("FAIL reset_out_idx got %0d want 0", bus_a.out_idx); end
        checks++; if (bus_a.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", bus_a.out_last); end
        checks++; if (bus_b.in_ready !== 1'b1 || bus_b.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_b got ready %b valid %b want 1 0", bus_b.in_ready, bus_b.out_valid);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed(input logic rv);
        logic [ABW-1:0] blk;
        int want;
        for (int j = 0; j < ABW / AP; j++) blk[j*AP +: AP] = 8'(j);
        bus_a.in_valid = 1'b1; bus_a.in_blk = blk; bus_a.in_rev = rv; bus_a.out_ready = 1'b1;
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready got %b want 1", bus_a.in_ready); end
        tick();
        bus_a.in_valid = 1'b0;
        for (int k = 0; k < AR; k++) begin
            want = rv ? AR - 1 - k : k;
            checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL dir_valid k=%0d got %b want 1", k, bus_a.out_valid); end
            checks++; if (bus_a.out_idx !== ARW'(want)) begin errors++; $display("FAIL dir_idx k=%0d got %0d want %0d", k, bus_a.out_idx, want); end
            checks++; if (bus_a.out_row !== dir_row(want)) begin errors++; $display("FAIL dir_row k=%0d got %h want %h", k, bus_a.out_row, dir_row(want)); end
            checks++; if (bus_a.out_last !== (k == AR - 1)) begin errors++; $display("FAIL dir_last k=%0d got %b want %b", k, bus_a.out_last, k == AR - 1); end
            tick();
        end
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL dir_drained got %b want 0", bus_a.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [ABW-1:0] blk [3];
        logic acc, pop;
        int acc_at;
        acc_at = -1;
        for (int i = 0; i < 3; i++) blk[i] = rand_blk_a();
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_a.in_valid = 1'b1; bus_a.in_blk = blk[i]; bus_a.in_rev = (i == 1);
            checks++; if (bus_a.in_ready !== (i < 2)) begin errors++; $display("FAIL b2b_fill_ready i=%0d got %b want %b", i, bus_a.in_ready, i < 2); end
            acc = bus_a.in_ready;
            tick();
            if (acc) push_a(blk[i], i == 1);
        end
        bus_a.out_ready = 1'b1;
        for (int cyc = 0; cyc < 3 * AR; cyc++) begin
            checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble cyc=%0d got %b want 1", cyc, bus_a.out_valid); end
            checks++; if (bus_a.in_ready !== ready_a()) begin errors++; $display("FAIL b2b_ready cyc=%0d got %b want %b", cyc, bus_a.in_ready, ready_a()); end
            if (exp_a.size() != 0) begin
                checks++; if ({bus_a.out_last, bus_a.out_idx, bus_a.out_row} !== exp_a[0]) begin
                    errors++; $display("FAIL b2b_row cyc=%0d got %b %0d %h want %h", cyc, bus_a.out_last, bus_a.out_idx, bus_a.out_row, exp_a[0]);
                end
            end
            acc = bus_a.in_valid & bus_a.in_ready;
            pop = bus_a.out_valid & bus_a.out_ready;
            tick();
            if (pop && exp_a.size() != 0) void'(exp_a.pop_front());
            if (acc) begin push_a(blk[2], 1'b0); acc_at = cyc; bus_a.in_valid = 1'b0; end
        end
        checks++; if (acc_at != AR) begin errors++; $display("FAIL b2b_third_accept got cycle %0d want %0d", acc_at, AR); end
        checks++; if (bus_a.out_valid !== 1'b0 || exp_a.size() != 0) begin
            errors++; $display("FAIL b2b_end got valid %b left %0d want 0 0", bus_a.out_valid, exp_a.size());
        end
    endtask

    task automatic test_random();
        logic [ABW-1:0] blk;
        logic rv, acc, pop;
        int sent, cyc;
        sent = 0; cyc = 0;
        blk = rand_blk_a(); rv = 1'($urandom_range(0, 1));
        while ((sent < 100 || exp_a.size() != 0) && cyc < 6000) begin
            bus_a.in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
            bus_a.in_blk = blk; bus_a.in_rev = rv;
            bus_a.out_ready = 1'($urandom_range(0, 1));
            checks++; if (bus_a.in_ready !== ready_a()) begin errors++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, bus_a.in_ready, ready_a()); end
            checks++; if (bus_a.out_valid !== (exp_a.size() != 0)) begin errors++; $display("FAIL rand_valid cyc=%0d got %b want %b", cyc, bus_a.out_valid, exp_a.size() != 0); end
            if (exp_a.size() != 0) begin
                checks++; if ({bus_a.out_last, bus_a.out_idx, bus_a.out_row} !== exp_a[0]) begin
                    errors++; $display("FAIL rand_row cyc=%0d got %b %0d %h want %h", cyc, bus_a.out_last, bus_a.out_idx, bus_a.out_row, exp_a[0]);
                end
            end
            acc = bus_a.in_valid & bus_a.in_ready;
            pop = bus_a.out_valid & bus_a.out_ready;
            tick();
            if (pop && exp_a.size() != 0) void'(exp_a.pop_front());
            if (acc) begin push_a(blk, rv); sent++; blk = rand_blk_a(); rv = 1'($urandom_range(0, 1)); end
            cyc++;
        end
        bus_a.in_valid = 1'b0;
        checks++; if (cyc >= 6000) begin errors++; $display("FAIL rand_timeout sent %0d left %0d want 100 0", sent, exp_a.size()); end
    endtask

    task automatic test_accept_retire();
        logic [ABW-1:0] blk0, blk1;
        logic rv1, acc, pop;
        blk0 = rand_blk_a(); blk1 = rand_blk_a(); rv1 = 1'($urandom_range(0, 1));
        bus_a.in_valid = 1'b1; bus_a.in_blk = blk0; bus_a.in_rev = 1'b0; bus_a.out_ready = 1'b1;
        tick();
        push_a(blk0, 1'b0);
        bus_a.in_valid = 1'b0;
        for (int k = 0; k < AR; k++) begin
            if (k == AR - 1) begin bus_a.in_valid = 1'b1; bus_a.in_blk = blk1; bus_a.in_rev = rv1; end
            checks++; if (bus_a.out_last !== (k == AR - 1)) begin errors++; $display("FAIL ar_last k=%0d got %b want %b", k, bus_a.out_last, k == AR - 1); end
            acc = bus_a.in_valid & bus_a.in_ready;
            pop = bus_a.out_valid & bus_a.out_ready;
            tick();
            if (pop && exp_a.size() != 0) void'(exp_a.pop_front());
            if (acc) push_a(blk1, rv1);
            bus_a.in_valid = 1'b0;
        end
        checks++; if (exp_a.size() != AR) begin errors++; $display("FAIL ar_accept got %0d rows queued want %0d", exp_a.size(), AR); end
        for (int k = 0; k < AR; k++) begin
            checks++; if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b1) begin
                errors++; $display("FAIL ar_occupancy k=%0d got ready %b valid %b want 1 1", k, bus_a.in_ready, bus_a.out_valid);
            end
            if (exp_a.size() != 0) begin
                checks++; if ({bus_a.out_last, bus_a.out_idx, bus_a.out_row} !== exp_a[0]) begin
                    errors++; $display("FAIL ar_row k=%0d got %b %0d %h want %h", k, bus_a.out_last, bus_a.out_idx, bus_a.out_row, exp_a[0]);
                end
                void'(exp_a.pop_front());
            end
            tick();
        end
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL ar_drained got %b want 0", bus_a.out_valid); end
    endtask

    task automatic test_flush_a(input logic use_rst);
        logic [ABW-1:0] blk0, blk1, blk2;
        blk0 = rand_blk_a(); blk1 = rand_blk_a(); blk2 = rand_blk_a();
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_blk = blk0; bus_a.in_rev = 1'b0;
        tick(); push_a(blk0, 1'b0);
        bus_a.in_blk = blk1; bus_a.in_rev = 1'b1;
        tick(); push_a(blk1, 1'b1);
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
        repeat (3) begin tick(); void'(exp_a.pop_front()); end
        checks++; if (bus_a.out_idx !== 3'd3 || bus_a.in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_pre got idx %0d ready %b want 3 0", bus_a.out_idx, bus_a.in_ready);
        end
        if (use_rst) rst = 1'b1; else flush_a = 1'b1;
        bus_a.in_valid = 1'b1; bus_a.in_blk = blk2;
        tick();
        rst = 1'b0; flush_a = 1'b0; bus_a.in_valid = 1'b0;
        exp_a.delete();
        checks++; if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state rst=%b got valid %b ready %b want 0 1", use_rst, bus_a.out_valid, bus_a.in_ready);
        end
        checks++; if (bus_a.out_row !== '0 || bus_a.out_idx !== '0 || bus_a.out_last !== 1'b0) begin
            errors++; $display("FAIL flush_outputs rst=%b got %h %0d %b want 0 0 0", use_rst, bus_a.out_row, bus_a.out_idx, bus_a.out_last);
        end
        bus_a.in_valid = 1'b1; bus_a.in_blk = blk2; bus_a.in_rev = 1'b0;
        tick(); push_a(blk2, 1'b0);
        bus_a.in_valid = 1'b0;
        for (int k = 0; k < AR; k++) begin
            checks++; if (exp_a.size() == 0 || {bus_a.out_last, bus_a.out_idx, bus_a.out_row} !== exp_a[0]) begin
                errors++; $display("FAIL flush_restart k=%0d got %b %0d %h", k, bus_a.out_last, bus_a.out_idx, bus_a.out_row);
            end
            if (exp_a.size() != 0) void'(exp_a.pop_front());
            tick();
        end
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drained got %b want 0", bus_a.out_valid); end
    endtask

    task automatic test_params_b();
        logic [BBW-1:0] blk;
        logic rv, acc, pop;
        int sent, cyc;
        bus_b.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            blk = rand_blk_b();
            bus_b.in_valid = 1'b1; bus_b.in_blk = blk; bus_b.in_rev = (i == 1);
            checks++; if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL b_fill_ready i=%0d got %b want 1", i, bus_b.in_ready); end
            tick(); push_b(blk, i == 1);
        end
        bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if ({bus_b.out_last, bus_b.out_idx, bus_b.out_row} !== exp_b[0]) begin
                errors++; $display("FAIL b_row k=%0d got %b %0d %h want %h", k, bus_b.out_last, bus_b.out_idx, bus_b.out_row, exp_b[0]);
            end
            tick(); void'(exp_b.pop_front());
        end
        checks++; if (bus_b.out_idx !== 2'd3 || bus_b.out_last !== 1'b1 || bus_b.in_ready !== 1'b0) begin
            errors++; $display("FAIL b_pre_flush got idx %0d last %b ready %b want 3 1 0", bus_b.out_idx, bus_b.out_last, bus_b.in_ready);
        end
        flush_b = 1'b1;
        tick();
        flush_b = 1'b0;
        exp_b.delete();
        checks++; if (bus_b.out_valid !== 1'b0 || bus_b.in_ready !== 1'b1) begin
            errors++; $display("FAIL b_flush got valid %b ready %b want 0 1", bus_b.out_valid, bus_b.in_ready);
        end
        sent = 0; cyc = 0;
        blk = rand_blk_b(); rv = 1'($urandom_range(0, 1));
        while ((sent < 40 || exp_b.size() != 0) && cyc < 3000) begin
            bus_b.in_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
            bus_b.in_blk = blk; bus_b.in_rev = rv;
            bus_b.out_ready = 1'($urandom_range(0, 1));
            checks++; if (bus_b.in_ready !== ready_b()) begin errors++; $display("FAIL b_rand_ready cyc=%0d got %b want %b", cyc, bus_b.in_ready, ready_b()); end
            checks++; if (bus_b.out_valid !== (exp_b.size() != 0)) begin errors++; $display("FAIL b_rand_valid cyc=%0d got %b want %b", cyc, bus_b.out_valid, exp_b.size() != 0); end
            if (exp_b.size() != 0) begin
                checks++; if ({bus_b.out_last, bus_b.out_idx, bus_b.out_row} !== exp_b[0]) begin
                    errors++; $display("FAIL b_rand_row cyc=%0d got %b %0d %h want %h", cyc, bus_b.out_last, bus_b.out_idx, bus_b.out_row, exp_b[0]);
                end
            end
            acc = bus_b.in_valid & bus_b.in_ready;
            pop = bus_b.out_valid & bus_b.out_ready;
            tick();
            if (pop && exp_b.size() != 0) void'(exp_b.pop_front());
            if (acc) begin push_b(blk, rv); sent++; blk = rand_blk_b(); rv = 1'($urandom_range(0, 1)); end
            cyc++;
        end
        bus_b.in_valid = 1'b0;
        checks++; if (cyc >= 3000) begin errors++; $display("FAIL b_rand_timeout sent %0d left %0d want 40 0", sent, exp_b.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed(1'b0);
        test_directed(1'b1);
        test_back_to_back();
        test_random();
        test_accept_retire();
        test_flush_a(1'b0);
        test_flush_a(1'b1);
        test_params_b();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog run did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
